// File: rtl/serial_sub_unit_if.sv
// Handshake bundle for the bit-serial subtractor: operand side, result side and status.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the flow control between producer, unit and consumer.
interface serial_sub_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             busy;

    // Producer/consumer side: drives operands and accepts results
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, busy
    );

    // Subtractor side
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, busy
    );
endinterface

// File: rtl/serial_sub_unit.sv
// Bit-serial A - B subtractor, LSB first, one full-subtract cell plus a borrow flop.
// Latency: result valid WIDTH cycles after the accept edge; one result per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module serial_sub_unit #(
    parameter int WIDTH     = 8,
    parameter int USE_CONST = 0,
    parameter int CONST_B   = 2,
    parameter int SATURATE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    serial_sub_unit_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CONST_W  = WIDTH'(CONST_B);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             init_q;     // low until the first edge after reset release
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res_next;

    // Single full-subtract cell working on the current LSBs
    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_next = {d_bit, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_LAST);
    assign b_eff    = (USE_CONST != 0) ? CONST_W : bus.in_b;
    assign accept   = in_ready & bus.in_valid;

    // State register and the post-reset ready qualifier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = init_q;
                if (init_q && bus.in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, serial shift and result load on DONE entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            if (state_q == IDLE && accept) begin
                a_q   <= bus.in_a;
                b_q   <= b_eff;
                br_q  <= 1'b0;
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                a_q   <= {1'b0, a_q[WIDTH-1:1]};
                b_q   <= {1'b0, b_q[WIDTH-1:1]};
                res_q <= res_next;
                br_q  <= br_next;
                cnt_q <= cnt_q + 1'b1;
                if (last_bit) begin
                    // Underflow clamps to zero only when saturation is enabled
                    diff_q   <= ((SATURATE != 0) && br_next) ? '0 : res_next;
                    borrow_q <= br_next;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = busy;
    assign bus.out_diff   = diff_q;
    assign bus.out_borrow = borrow_q;
endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed bench for serial_sub_unit: three instances (plain, saturating, constant-subtrahend).
// Latency: checks first out_valid exactly 8 cycles after accept and 10-cycle streaming cadence.
// Backpressure: holds out_ready low in DONE and queues a new operand behind the stalled result.
module tb_serial_sub_unit;
    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] ivld;
    logic [2:0] ordy;
    int         cyc;
    int         n_checks;
    int         n_fail;

    serial_sub_unit_if #(.WIDTH(8)) if0 ();
    serial_sub_unit_if #(.WIDTH(8)) if1 ();
    serial_sub_unit_if #(.WIDTH(8)) if2 ();

    serial_sub_unit #(.WIDTH(8), .USE_CONST(0), .CONST_B(2), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    serial_sub_unit #(.WIDTH(8), .USE_CONST(0), .CONST_B(2), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    serial_sub_unit #(.WIDTH(8), .USE_CONST(1), .CONST_B(2), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    assign if0.in_valid = ivld[0];
    assign if1.in_valid = ivld[1];
    assign if2.in_valid = ivld[2];
    assign if0.out_ready = ordy[0];
    assign if1.out_ready = ordy[1];
    assign if2.out_ready = ordy[2];
    assign if0.in_a = a;
    assign if1.in_a = a;
    assign if2.in_a = a;
    assign if0.in_b = b;
    assign if1.in_b = b;
    assign if2.in_b = b;

    logic [2:0]      rdy;
    logic [2:0]      ov;
    logic [2:0]      ob;
    logic [2:0]      bz;
    logic [2:0][7:0] od;
    assign rdy = {if2.in_ready, if1.in_ready, if0.in_ready};
    assign ov  = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign ob  = {if2.out_borrow, if1.out_borrow, if0.out_borrow};
    assign bz  = {if2.busy, if1.busy, if0.busy};
    assign od  = {if2.out_diff, if1.out_diff, if0.out_diff};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One full operation on instance sel; operands are scrambled right after accept
    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] diff, output logic bor,
                          output int lat, output int acc_cyc);
        int   guard;
        logic old_rdy;
        old_rdy   = ordy[sel];
        a         = av;
        b         = bv;
        ivld[sel] = 1'b1;
        guard     = 0;
        while (rdy[sel] !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready=%b, required 1 within 40 cycles", sel, rdy[sel]);
        end
        @(posedge clk); #1;
        acc_cyc   = cyc;
        ivld[sel] = 1'b0;
        a         = ~av;
        b         = ~bv;
        lat       = 0;
        while (ov[sel] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat >= 40) begin
            n_fail++;
            $display("FAIL result_timeout dut%0d: out_valid=%b, required 1 within 40 cycles", sel, ov[sel]);
        end
        diff      = od[sel];
        bor       = ob[sel];
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = old_rdy;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({rdy[0], ov[0], od[0], ob[0], bz[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b diff=%h bor=%b busy=%b, required all 0",
                     rdy[0], ov[0], od[0], ob[0], bz[0]);
        end
        #10;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdy !== 3'b000) begin
            n_fail++;
            $display("FAIL ready_before_edge: in_ready=%b, required 000", rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rdy !== 3'b111 || ov !== 3'b000 || bz !== 3'b000) begin
            n_fail++;
            $display("FAIL ready_after_edge: in_ready=%b vld=%b busy=%b, required 111 000 000", rdy, ov, bz);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic       br;
        int         lat;
        int         ac;
        run_op(0, 8'd5, 8'd3, d, br, lat, ac);
        n_checks++;
        if (d !== 8'h02 || br !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_5_3: diff=%h bor=%b, required 02 0", d, br);
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: %0d cycles, required 8", lat);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] d;
        logic       br;
        int         lat;
        int         ac;
        run_op(0, 8'd3, 8'd5, d, br, lat, ac);
        n_checks++;
        if (d !== 8'hFE || br !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_wrap: diff=%h bor=%b, required fe 1", d, br);
        end
        run_op(1, 8'd3, 8'd5, d, br, lat, ac);
        n_checks++;
        if (d !== 8'h00 || br !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_sat: diff=%h bor=%b, required 00 1", d, br);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] te [3];
        logic       tr [3];
        logic [7:0] d;
        logic       br;
        int         lat;
        int         ac;
        ta[0] = 8'h00; tb[0] = 8'hFF; te[0] = 8'h01; tr[0] = 1'b1;
        ta[1] = 8'hFF; tb[1] = 8'hFF; te[1] = 8'h00; tr[1] = 1'b0;
        ta[2] = 8'hFF; tb[2] = 8'h00; te[2] = 8'hFF; tr[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_op(0, ta[i], tb[i], d, br, lat, ac);
            n_checks++;
            if (d !== te[i] || br !== tr[i]) begin
                n_fail++;
                $display("FAIL boundary_%h_%h: diff=%h bor=%b, required %h %b",
                         ta[i], tb[i], d, br, te[i], tr[i]);
            end
        end
    endtask

    task automatic test_const();
        logic [7:0] d;
        logic       br;
        int         lat;
        int         ac;
        run_op(2, 8'd14, 8'hAA, d, br, lat, ac);
        n_checks++;
        if (d !== 8'h0C || br !== 1'b0) begin
            n_fail++;
            $display("FAIL const_14: diff=%h bor=%b, required 0c 0", d, br);
        end
        run_op(2, 8'd1, 8'h00, d, br, lat, ac);
        n_checks++;
        if (d !== 8'h00 || br !== 1'b1) begin
            n_fail++;
            $display("FAIL const_1_sat: diff=%h bor=%b, required 00 1", d, br);
        end
    endtask

    task automatic test_hold();
        int guard;
        a = 8'd20; b = 8'd7;
        ivld[0] = 1'b1;
        @(posedge clk); #1;
        ivld[0] = 1'b0;
        a = 8'd50; b = 8'd8;
        guard = 0;
        while (ov[0] !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard !== 8) begin
            n_fail++;
            $display("FAIL hold_latency: %0d cycles, required 8", guard);
        end
        // A second operand waits while the result is stalled
        ivld[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ov[0] !== 1'b1 || od[0] !== 8'h0D || rdy[0] !== 1'b0 || bz[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: vld=%b diff=%h rdy=%b busy=%b, required 1 0d 0 0",
                         i, ov[0], od[0], rdy[0], bz[0]);
            end
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b0 || od[0] !== 8'h0D || rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: vld=%b diff=%h rdy=%b, required 0 0d 1", ov[0], od[0], rdy[0]);
        end
        @(posedge clk); #1;
        ivld[0] = 1'b0;
        n_checks++;
        if (bz[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_pending_accept: busy=%b, required 1", bz[0]);
        end
        guard = 0;
        while (ov[0] !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (ov[0] !== 1'b1 || od[0] !== 8'h2A || ob[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_second_result: vld=%b diff=%h bor=%b, required 1 2a 0", ov[0], od[0], ob[0]);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] sa [3];
        logic [7:0] sb [3];
        logic [7:0] se [3];
        logic [7:0] d;
        logic       br;
        int         lat;
        int         ac;
        int         prev_ac;
        sa[0] = 8'd100; sb[0] = 8'd1;  se[0] = 8'd99;
        sa[1] = 8'd7;   sb[1] = 8'd9;  se[1] = 8'hFE;
        sa[2] = 8'd200; sb[2] = 8'd55; se[2] = 8'd145;
        ordy[0] = 1'b1;
        prev_ac = 0;
        for (int i = 0; i < 3; i++) begin
            run_op(0, sa[i], sb[i], d, br, lat, ac);
            n_checks++;
            if (d !== se[i] || lat !== 8) begin
                n_fail++;
                $display("FAIL stream%0d: diff=%h latency=%0d, required %h 8", i, d, lat, se[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (ac - prev_ac !== 10) begin
                    n_fail++;
                    $display("FAIL stream_cadence%0d: %0d cycles between accepts, required 10", i, ac - prev_ac);
                end
            end
            prev_ac = ac;
        end
        ordy[0] = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic       br;
        int         lat;
        int         ac;
        logic       seen;
        a = 8'h33; b = 8'h11;
        ivld[0] = 1'b1;
        @(posedge clk); #1;
        ivld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        n_checks++;
        if (bz[0] !== 1'b1 || od[0] !== 8'd145) begin
            n_fail++;
            $display("FAIL abort_precondition: busy=%b diff=%h, required 1 91", bz[0], od[0]);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rdy[0], ov[0], od[0], ob[0], bz[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_outputs: rdy=%b vld=%b diff=%h bor=%b busy=%b, required all 0",
                     rdy[0], ov[0], od[0], ob[0], bz[0]);
        end
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: in_ready=%b, required 1", rdy[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ov[0] !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stray_valid: out_valid seen=%b, required 0", seen);
        end
        run_op(0, 8'd9, 8'd4, d, br, lat, ac);
        n_checks++;
        if (d !== 8'h05 || br !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL abort_next_op: diff=%h bor=%b latency=%0d, required 05 0 8", d, br, lat);
        end
    endtask

    initial begin
        rst      = 1'b0;
        ivld     = 3'b000;
        ordy     = 3'b000;
        a        = 8'h00;
        b        = 8'h00;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_underflow();
        test_boundaries();
        test_const();
        test_hold();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
        $fatal(1, "watchdog");
    end
endmodule
